// File: rtl/pt_pkg.sv
// Shared Pan-Tompkins decision-stage definitions.
// Holds the sample-rate constants for 200 Hz operation, the decision FSM
// state encoding and the heart-rate regularity encoding.
// No ports.
package pt_pkg;

  // Sample-rate constants at 200 Hz.
  localparam int PT1000MS      = 200;
  localparam int REFRACT_200MS = 40;

  // RR-limit percentages used by the RR statistics block.
  localparam int RR92_PCT  = 92;
  localparam int RR116_PCT = 116;
  localparam int RR166_PCT = 166;

  // state      | meaning
  // REFRACT    | refractory window after a QRS, peaks ignored
  // SCAN       | classifying peaks, tracking searchback candidate
  // SB         | one-clock searchback commit of the held candidate
  typedef enum logic [1:0] {
    ST_REFRACT = 2'd0,
    ST_SCAN    = 2'd1,
    ST_SB      = 2'd2
  } qrs_state_e;

  typedef enum logic {
    HR_REGULAR   = 1'b0,
    HR_IRREGULAR = 1'b1
  } hr_mode_e;

endpackage

// File: rtl/pt_elapsed_counter.sv
// Samples-since-last-QRS counter.
// Ports:
//   clk, rstn           clock, async active-low reset
//   en_i                global enable; low holds the count
//   inc_i               add one (saturating at the signed maximum)
//   sub_i, sub_val_i    subtract sub_val_i before the increment
//   clr_i               force the count to zero (overrides inc/sub)
//   count_o             registered count
//   count_next_o        count after subtract and increment, before clear;
//                       this is the "new elapsed" the FSM compares against
module pt_elapsed_counter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en_i,
  input  logic                         inc_i,
  input  logic                         sub_i,
  input  logic signed [DATA_WIDTH-1:0] sub_val_i,
  input  logic                         clr_i,
  output logic signed [DATA_WIDTH-1:0] count_o,
  output logic signed [DATA_WIDTH-1:0] count_next_o
);

  localparam logic signed [DATA_WIDTH-1:0] CNT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic signed [DATA_WIDTH-1:0] count_q;
  logic signed [DATA_WIDTH-1:0] base;

  always_comb begin
    base         = sub_i ? (count_q - sub_val_i) : count_q;
    count_next_o = (inc_i && (base != CNT_MAX)) ? (base + 1'b1) : base;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= clr_i ? '0 : count_next_o;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/qrs_decision_ctrl.sv
// Pan-Tompkins decision-stage sequencer between the peak detector and the
// RR statistics block. Enforces refractory, classifies peaks against the
// signal/searchback thresholds and commits a searchback candidate when the
// RR-miss limit expires. Emits a one-cycle rru/qrs_pulse with rr_interval.
// Ports:
//   clk, rstn, en                 clock, async active-low reset, enable
//   sample_valid, peak_valid      sample strobe and peak flag
//   peak_amp, thr_i1, thr_i2      signed amplitude and thresholds
//   rrmiss                        signed RR-miss limit in samples
//   rru, qrs_pulse, searchback    one-cycle update strobes
//   rr_interval                   latest QRS interval, held between strobes
//   state_o                       FSM state for debug
// Optional build macro QRS_CTRL_STATS_EN adds beat_count and sb_count.
module qrs_decision_ctrl
  import pt_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int REFRACT_SAMPLES = REFRACT_200MS,
  parameter int RR_INIT         = PT1000MS
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         sample_valid,
  input  logic                         peak_valid,
  input  logic signed [DATA_WIDTH-1:0] peak_amp,
  input  logic signed [DATA_WIDTH-1:0] thr_i1,
  input  logic signed [DATA_WIDTH-1:0] thr_i2,
  input  logic signed [DATA_WIDTH-1:0] rrmiss,
  output logic                         rru,
  output logic signed [DATA_WIDTH-1:0] rr_interval,
  output logic                         qrs_pulse,
  output logic                         searchback,
`ifdef QRS_CTRL_STATS_EN
  output logic [15:0]                  beat_count,
  output logic [15:0]                  sb_count,
`endif
  output logic [1:0]                   state_o
);

  localparam logic signed [DATA_WIDTH-1:0] REFRACT_S = DATA_WIDTH'(REFRACT_SAMPLES);
  localparam logic signed [DATA_WIDTH-1:0] RR_INIT_S = DATA_WIDTH'(RR_INIT);

  qrs_state_e state_q, state_d, eval_st;

  logic signed [DATA_WIDTH-1:0] rr_q, rr_d;
  logic signed [DATA_WIDTH-1:0] cand_amp_q, cand_amp_d;
  logic signed [DATA_WIDTH-1:0] cand_idx_q, cand_idx_d;
  logic                         cand_vld_q, cand_vld_d;
  logic                         rru_q, rru_d;
  logic                         sb_q, sb_d;

  logic signed [DATA_WIDTH-1:0] el_q, el_new, post_sb;
  logic                         cnt_inc, cnt_sub, cnt_clr;

  // inc/sub depend only on inputs and state, keeping the counter's
  // combinational "new elapsed" free of any loop through the FSM logic.
  assign cnt_inc = en && sample_valid;
  assign cnt_sub = en && (state_q == ST_SB);

  pt_elapsed_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_elapsed (
    .clk         (clk),
    .rstn        (rstn),
    .en_i        (en),
    .inc_i       (cnt_inc),
    .sub_i       (cnt_sub),
    .sub_val_i   (cand_idx_q),
    .clr_i       (cnt_clr),
    .count_o     (el_q),
    .count_next_o(el_new)
  );

  always_comb begin
    state_d    = state_q;
    eval_st    = state_q;
    rr_d       = rr_q;
    cand_amp_d = cand_amp_q;
    cand_idx_d = cand_idx_q;
    cand_vld_d = cand_vld_q;
    rru_d      = 1'b0;
    sb_d       = 1'b0;
    cnt_clr    = 1'b0;
    post_sb    = el_q - cand_idx_q;

    if (en) begin
      // SB commits first; a coincident sample is then evaluated in the
      // state SB would hand over to, against the already-adjusted count.
      if (state_q == ST_SB) begin
        rr_d       = cand_idx_q;
        rru_d      = 1'b1;
        sb_d       = 1'b1;
        cand_vld_d = 1'b0;
        cand_amp_d = '0;
        cand_idx_d = '0;
        eval_st    = (post_sb < REFRACT_S) ? ST_REFRACT : ST_SCAN;
        state_d    = eval_st;
      end

      if (sample_valid) begin
        // The sample that ends the refractory window is already classified.
        if ((eval_st == ST_REFRACT) && (el_new >= REFRACT_S)) begin
          eval_st = ST_SCAN;
          state_d = ST_SCAN;
        end

        if (eval_st == ST_SCAN) begin
          if (peak_valid && (peak_amp > thr_i1)) begin
            rr_d       = el_new;
            rru_d      = 1'b1;
            sb_d       = 1'b0;
            cnt_clr    = 1'b1;
            cand_vld_d = 1'b0;
            cand_amp_d = '0;
            cand_idx_d = '0;
            state_d    = ST_REFRACT;
          end else begin
            if (peak_valid && (peak_amp > thr_i2) &&
                (!cand_vld_d || (peak_amp > cand_amp_d))) begin
              cand_vld_d = 1'b1;
              cand_amp_d = peak_amp;
              cand_idx_d = el_new;
            end
            if ((el_new > rrmiss) && cand_vld_d) begin
              state_d = ST_SB;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_REFRACT;
      rr_q       <= RR_INIT_S;
      cand_amp_q <= '0;
      cand_idx_q <= '0;
      cand_vld_q <= 1'b0;
      rru_q      <= 1'b0;
      sb_q       <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cand_amp_q <= cand_amp_d;
      cand_idx_q <= cand_idx_d;
      cand_vld_q <= cand_vld_d;
      rru_q      <= rru_d;
      sb_q       <= sb_d;
    end else begin
      rru_q <= 1'b0;
      sb_q  <= 1'b0;
    end
  end

`ifdef QRS_CTRL_STATS_EN
  logic [15:0] beat_q, sbc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_q <= '0;
      sbc_q  <= '0;
    end else if (en) begin
      if (rru_d && (beat_q != 16'hFFFF)) beat_q <= beat_q + 16'd1;
      if (sb_d && (sbc_q != 16'hFFFF))   sbc_q  <= sbc_q + 16'd1;
    end
  end

  assign beat_count = beat_q;
  assign sb_count   = sbc_q;
`endif

  assign rru         = rru_q;
  assign qrs_pulse   = rru_q;
  assign searchback  = sb_q;
  assign rr_interval = rr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_qrs_decision_ctrl.sv
// Directed bench for qrs_decision_ctrl: drives inputs on the falling edge
// and checks registered outputs on the following falling edge.
module tb_qrs_decision_ctrl;

  logic               clk;
  logic               rstn;
  logic               en;
  logic               sample_valid;
  logic               peak_valid;
  logic signed [15:0] peak_amp;
  logic signed [15:0] thr_i1;
  logic signed [15:0] thr_i2;
  logic signed [15:0] rrmiss;
  logic               rru;
  logic signed [15:0] rr_interval;
  logic               qrs_pulse;
  logic               searchback;
  logic [1:0]         state_o;
`ifdef QRS_CTRL_STATS_EN
  logic [15:0]        beat_count;
  logic [15:0]        sb_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  qrs_decision_ctrl #(
    .DATA_WIDTH     (16),
    .REFRACT_SAMPLES(40),
    .RR_INIT        (200)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .sample_valid(sample_valid),
    .peak_valid  (peak_valid),
    .peak_amp    (peak_amp),
    .thr_i1      (thr_i1),
    .thr_i2      (thr_i2),
    .rrmiss      (rrmiss),
    .rru         (rru),
    .rr_interval (rr_interval),
    .qrs_pulse   (qrs_pulse),
    .searchback  (searchback),
`ifdef QRS_CTRL_STATS_EN
    .beat_count  (beat_count),
    .sb_count    (sb_count),
`endif
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    peak_valid   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic samp(input logic pk, input int amp);
    sample_valid = 1'b1;
    peak_valid   = pk;
    peak_amp     = 16'(amp);
    @(negedge clk);
    sample_valid = 1'b0;
    peak_valid   = 1'b0;
  endtask

  task automatic n_samp(input int n);
    repeat (n) samp(1'b0, 0);
  endtask

  initial begin
    rstn         = 1'b0;
    en           = 1'b1;
    sample_valid = 1'b0;
    peak_valid   = 1'b0;
    peak_amp     = '0;
    thr_i1       = 16'sd500;
    thr_i2       = 16'sd250;
    rrmiss       = 16'sd1000;

    // 1. reset values and refractory exit after 40 samples
    idle(2);
    check("rst_rr", rr_interval, 200);
    check("rst_rru", rru, 0);
    check("rst_qrs", qrs_pulse, 0);
    check("rst_sb", searchback, 0);
    check("rst_state", state_o, 0);
    rstn = 1'b1;
    idle(1);
    n_samp(39);
    check("refr_39", state_o, 0);
    samp(1'b0, 0);
    check("refr_40", state_o, 1);

    // 2. regular beats every 160 samples
    n_samp(119);
    samp(1'b1, 1000);
    check("reg1_rru", rru, 1);
    check("reg1_qrs", qrs_pulse, 1);
    check("reg1_sb", searchback, 0);
    check("reg1_rr", rr_interval, 160);
    check("reg1_state", state_o, 0);
    idle(1);
    check("reg1_rru_off", rru, 0);
    check("reg1_qrs_off", qrs_pulse, 0);
    n_samp(159);
    samp(1'b1, 1000);
    check("reg2_rru", rru, 1);
    check("reg2_rr", rr_interval, 160);

    // 3. refractory: peak at 30 ignored, at 40 accepted
    n_samp(29);
    samp(1'b1, 1000);
    check("refr30_rru", rru, 0);
    check("refr30_state", state_o, 0);
    n_samp(9);
    samp(1'b1, 1000);
    check("refr40_rru", rru, 1);
    check("refr40_rr", rr_interval, 40);

    // 4. searchback: best candidate 400 at 180, expiry at 333
    rrmiss = 16'sd332;
    n_samp(149);
    samp(1'b1, 300);
    check("sb_c150_rru", rru, 0);
    n_samp(29);
    samp(1'b1, 400);
    n_samp(19);
    samp(1'b1, 350);
    n_samp(132);
    check("sb_332_state", state_o, 1);
    samp(1'b0, 0);
    check("sb_333_state", state_o, 2);
    check("sb_333_rru", rru, 0);
    idle(1);
    check("sb_rru", rru, 1);
    check("sb_qrs", qrs_pulse, 1);
    check("sb_flag", searchback, 1);
    check("sb_rr", rr_interval, 180);
    check("sb_state", state_o, 1);
    idle(1);
    check("sb_rru_off", rru, 0);
    check("sb_flag_off", searchback, 0);
    // elapsed resumes from 153: peak 7 samples later gives 160
    n_samp(6);
    samp(1'b1, 1000);
    check("post_sb_rru", rru, 1);
    check("post_sb_rr", rr_interval, 160);
    check("post_sb_flag", searchback, 0);

    // 5. coincidence: strong peak on the expiry sample wins
    n_samp(99);
    samp(1'b1, 300);
    n_samp(232);
    samp(1'b1, 600);
    check("coin_rru", rru, 1);
    check("coin_rr", rr_interval, 333);
    check("coin_sb", searchback, 0);
    check("coin_state", state_o, 0);
    idle(1);
    check("coin_state2", state_o, 0);

    // expiry without a candidate stays in SCAN
    rrmiss = 16'sd30;
    n_samp(50);
    check("nocand_state", state_o, 1);

    // 6. en low freezes everything
    en           = 1'b0;
    sample_valid = 1'b1;
    peak_valid   = 1'b1;
    peak_amp     = 16'sd1000;
    repeat (50) @(negedge clk);
    idle(1);
    check("frz_rru", rru, 0);
    check("frz_state", state_o, 1);
    check("frz_rr", rr_interval, 333);
    en = 1'b1;
    n_samp(9);
    samp(1'b1, 1000);
    check("frz_after_rru", rru, 1);
    check("frz_after_rr", rr_interval, 60);
    en = 1'b0;
    idle(1);
    check("en_low_rru", rru, 0);
    check("en_low_qrs", qrs_pulse, 0);
    check("en_low_rr", rr_interval, 60);
    en = 1'b1;
    idle(1);

    // reset pulse during SB
    rrmiss = 16'sd100;
    n_samp(49);
    samp(1'b1, 300);
    n_samp(50);
    samp(1'b0, 0);
    check("rstsb_state", state_o, 2);
    rstn = 1'b0;
    idle(1);
    check("rstsb_rru", rru, 0);
    check("rstsb_sb", searchback, 0);
    check("rstsb_rr", rr_interval, 200);
    check("rstsb_state0", state_o, 0);
    rstn = 1'b1;
    idle(1);
    check("rstsb_rru2", rru, 0);
    n_samp(39);
    check("rstsb_refr39", state_o, 0);
    samp(1'b0, 0);
    check("rstsb_refr40", state_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
